// File: rtl/act_readout_seq_if.sv
// Handshake bundle between the activation readout sequencer, its control
// source, the accelerator read port and the downstream activation stream.
interface act_readout_seq_if;
    logic        start;
    logic [11:0] act_no;
    logic        busy;
    logic        done;
    logic        err;
    logic        read_en;
    logic        read_rdy;
    logic [15:0] read_addr;
    logic        read_data_vld;
    logic        read_data_rdy;
    logic [31:0] read_data;
    logic        out_vld;
    logic        out_rdy;
    logic [11:0] out_idx;
    logic [15:0] out_act;

    // sequencer side
    modport master (
        input  start, act_no, read_rdy, read_data_vld, read_data, out_rdy,
        output busy, done, err, read_en, read_addr, read_data_rdy,
               out_vld, out_idx, out_act
    );

    // environment side (control, accelerator, downstream sink)
    modport slave (
        output start, act_no, read_rdy, read_data_vld, read_data, out_rdy,
        input  busy, done, err, read_en, read_addr, read_data_rdy,
               out_vld, out_idx, out_act
    );
endinterface

// File: rtl/act_readout_seq.sv
// Activation readout sequencer: walks PE/activation addresses, bounds outstanding reads.
// Optional returned-index checking is built only when ACT_READOUT_CHECK_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_ISSUE | issuing reads and forwarding returned data
// S_DRAIN | all reads issued, collecting remaining data
// S_DONE  | one-cycle completion pulse
module act_readout_seq #(
    parameter int NUM_PE  = 64,
    parameter int MAX_OUT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    act_readout_seq_if.master  bus
);

    localparam logic [2:0] LP_MAX_OUT = 3'(MAX_OUT);
    localparam logic [5:0] LP_PE_LAST = 6'(NUM_PE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_act_no;
    logic [11:0] r_iss_cnt;
    logic [11:0] r_rcv_cnt;
    logic [2:0]  r_outst;
    logic [5:0]  r_pe_idx;
    logic [5:0]  r_act_addr;

    logic        w_start_acc;
    logic        w_active;
    logic        w_read_en;
    logic        w_rd_rdy;
    logic        w_issue;
    logic        w_receive;
    logic        w_unused;

    assign w_active  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_read_en = (r_state == S_ISSUE) && bus.read_rdy && (r_outst < LP_MAX_OUT);
    // data with nothing outstanding is a protocol error and is refused
    assign w_rd_rdy  = w_active && bus.out_rdy && (r_outst != 3'd0);
    assign w_issue   = w_read_en && bus.read_rdy;
    assign w_receive = bus.read_data_vld && w_rd_rdy;

    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_next      = (bus.act_no == 12'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue && (r_iss_cnt + 12'd1 == r_act_no))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_receive && (r_rcv_cnt + 12'd1 == r_act_no))
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_act_no   <= 12'd0;
            r_iss_cnt  <= 12'd0;
            r_rcv_cnt  <= 12'd0;
            r_outst    <= 3'd0;
            r_pe_idx   <= 6'd0;
            r_act_addr <= 6'd0;
        end else begin
            r_state <= w_next;
            if (w_start_acc) begin
                r_act_no   <= bus.act_no;
                r_iss_cnt  <= 12'd0;
                r_rcv_cnt  <= 12'd0;
                r_outst    <= 3'd0;
                r_pe_idx   <= 6'd0;
                r_act_addr <= 6'd0;
            end else begin
                if (w_issue) begin
                    r_iss_cnt <= r_iss_cnt + 12'd1;
                    if (r_pe_idx == LP_PE_LAST) begin
                        r_pe_idx   <= 6'd0;
                        r_act_addr <= r_act_addr + 6'd1;
                    end else begin
                        r_pe_idx <= r_pe_idx + 6'd1;
                    end
                end
                if (w_receive)
                    r_rcv_cnt <= r_rcv_cnt + 12'd1;
                case ({w_issue, w_receive})
                    2'b10:   r_outst <= r_outst + 3'd1;
                    2'b01:   r_outst <= r_outst - 3'd1;
                    default: r_outst <= r_outst;
                endcase
            end
        end
    end

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_DONE);
    assign bus.read_en       = w_read_en;
    assign bus.read_addr     = w_read_en ? {r_pe_idx, 4'b0000, r_act_addr} : 16'h0000;
    assign bus.read_data_rdy = w_rd_rdy;
    assign bus.out_vld       = w_active && bus.read_data_vld;
    assign bus.out_idx       = bus.read_data[27:16];
    assign bus.out_act       = bus.read_data[15:0];
    assign w_unused          = ^bus.read_data[31:28];

`ifdef ACT_READOUT_CHECK_EN
    // expected indices in issue order; depth 8 covers any MAX_OUT up to 7
    logic [11:0] r_exp_q [8];
    logic [2:0]  r_wr_ptr;
    logic [2:0]  r_rd_ptr;
    logic        r_err;

    always_ff @(posedge i_clk) begin
        if (w_issue)
            r_exp_q[r_wr_ptr] <= {r_pe_idx, r_act_addr};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_err    <= 1'b0;
        end else if (w_start_acc) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_issue)
                r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_receive) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
                if (bus.read_data[27:16] != r_exp_q[r_rd_ptr])
                    r_err <= 1'b1;
            end
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_act_readout_seq.sv
// Directed bench for act_readout_seq: table of readouts against a small accelerator
// model, plus hand sequences for reset, act_no=0, outstanding limit and mid-run reset.
module tb_act_readout_seq;

`ifdef ACT_READOUT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    act_readout_seq_if bus ();

    act_readout_seq #(.NUM_PE(64), .MAX_OUT(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          act_no;
        int          delay;
        int          stall_at;
        int          rdy_alt;
        int          mid_start;
        int          bad_k;
        int          k0, k1, k2;
        logic [15:0] a0, a1, a2;
    } row_t;

    row_t rows [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] act_val(input logic [11:0] idx);
        return {4'hA, idx};
    endfunction

    function automatic logic [15:0] exp_addr(input int k);
        logic [5:0] pe;
        logic [5:0] aa;
        pe = 6'(k % 64);
        aa = 6'(k / 64);
        return {pe, 4'b0000, aa};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input row_t r);
        int          iss, rcv, dn, cyc;
        logic [11:0] pend_idx [$];
        int          pend_due [$];
        logic [15:0] alog [128];
        logic [11:0] idx_ret;
        logic        vld;
        bit          exp_err;

        exp_err = (r.bad_k >= 0) && CHECK_EN;
        for (int i = 0; i < 128; i++) alog[i] = 16'hDEAD;
        bus.act_no        = 12'(r.act_no);
        bus.start         = 1'b1;
        bus.read_rdy      = 1'b0;
        bus.read_data_vld = 1'b0;
        bus.read_data     = 32'h0;
        bus.out_rdy       = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("err_clear_on_start", 32'(bus.err), 32'd0);

        iss = 0; rcv = 0; dn = 0; cyc = 0; idx_ret = 12'h0;
        while (dn == 0 && cyc < 2000) begin
            bus.read_rdy = (r.rdy_alt != 0) ? (cyc % 2 == 0) : 1'b1;
            bus.out_rdy  = !(r.stall_at >= 0 && cyc >= r.stall_at && cyc < r.stall_at + 10);
            bus.start    = (cyc == r.mid_start);
            bus.act_no   = (cyc == r.mid_start) ? 12'd1 : 12'(r.act_no);
            vld = (pend_idx.size() > 0) && (pend_due[0] <= cyc);
            if (vld) begin
                idx_ret = (rcv == r.bad_k) ? 12'd7 : pend_idx[0];
                bus.read_data = {4'h0, idx_ret, act_val(idx_ret)};
            end else begin
                bus.read_data = 32'h0;
            end
            bus.read_data_vld = vld;
            #1;
            if (bus.read_en && bus.read_rdy)
                chk("read_addr", 32'(bus.read_addr), 32'(exp_addr(iss)));
            else
                chk("read_addr_idle", 32'(bus.read_addr), 32'd0);
            if (vld && !bus.out_rdy)
                chk("rdy_during_stall", 32'(bus.read_data_rdy), 32'd0);
            if (vld && bus.read_data_rdy) begin
                chk("out_vld", 32'(bus.out_vld), 32'd1);
                chk("out_idx", 32'(bus.out_idx), 32'(idx_ret));
                chk("out_act", 32'(bus.out_act), 32'(act_val(idx_ret)));
                void'(pend_idx.pop_front());
                void'(pend_due.pop_front());
                rcv++;
            end
            if (bus.done) begin
                dn++;
                chk("err_at_done", 32'(bus.err), 32'(exp_err));
            end
            if (bus.read_en && bus.read_rdy) begin
                if (iss < 128) alog[iss] = bus.read_addr;
                pend_idx.push_back({bus.read_addr[15:10], bus.read_addr[5:0]});
                pend_due.push_back(cyc + r.delay);
                iss++;
            end
            step();
            cyc++;
        end
        bus.start = 1'b0;
        bus.read_data_vld = 1'b0;
        chk("done_seen", 32'(dn), 32'd1);
        chk("issue_count", 32'(iss), 32'(r.act_no));
        chk("recv_count", 32'(rcv), 32'(r.act_no));
        chk("spot_addr0", 32'(alog[r.k0]), 32'(r.a0));
        chk("spot_addr1", 32'(alog[r.k1]), 32'(r.a1));
        chk("spot_addr2", 32'(alog[r.k2]), 32'(r.a2));
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (bus.done) dn++;
            step();
        end
        chk("done_once", 32'(dn), 32'd1);
        chk("err_sticky", 32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        int n_en;
        int dn;
        n_checks = 0;
        n_errors = 0;

        rows[0] = '{act_no:5,  delay:1, stall_at:-1, rdy_alt:0, mid_start:-1, bad_k:-1,
                    k0:0,  k1:1,  k2:4,  a0:16'h0000, a1:16'h0400, a2:16'h1000};
        rows[1] = '{act_no:66, delay:1, stall_at:-1, rdy_alt:0, mid_start:-1, bad_k:-1,
                    k0:63, k1:64, k2:65, a0:16'hFC00, a1:16'h0001, a2:16'h0401};
        rows[2] = '{act_no:7,  delay:3, stall_at:2,  rdy_alt:0, mid_start:-1, bad_k:-1,
                    k0:0,  k1:5,  k2:6,  a0:16'h0000, a1:16'h1400, a2:16'h1800};
        rows[3] = '{act_no:3,  delay:2, stall_at:-1, rdy_alt:1, mid_start:2,  bad_k:-1,
                    k0:0,  k1:1,  k2:2,  a0:16'h0000, a1:16'h0400, a2:16'h0800};
        rows[4] = '{act_no:4,  delay:1, stall_at:-1, rdy_alt:0, mid_start:-1, bad_k:1,
                    k0:0,  k1:2,  k2:3,  a0:16'h0000, a1:16'h0800, a2:16'h0C00};

        // reset state with inputs that would otherwise provoke activity
        rst = 1'b1;
        bus.start = 1'b0;
        bus.act_no = 12'd0;
        bus.read_rdy = 1'b1;
        bus.read_data_vld = 1'b1;
        bus.read_data = 32'h0001_1234;
        bus.out_rdy = 1'b1;
        repeat (3) step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_read_en", 32'(bus.read_en), 32'd0);
        chk("rst_read_addr", 32'(bus.read_addr), 32'd0);
        chk("rst_read_data_rdy", 32'(bus.read_data_rdy), 32'd0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        bus.read_data_vld = 1'b0;
        rst = 1'b0;
        step();

        // act_no = 0 goes straight to DONE
        bus.act_no = 12'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_busy", 32'(bus.busy), 32'd1);
        chk("zero_read_en", 32'(bus.read_en), 32'd0);
        step();
        chk("zero_done_end", 32'(bus.done), 32'd0);
        chk("zero_busy_end", 32'(bus.busy), 32'd0);
        chk("zero_read_en_end", 32'(bus.read_en), 32'd0);

        for (int t = 0; t < 5; t++) run_row(rows[t]);

        // outstanding limit with a silent accelerator
        bus.act_no = 12'd10;
        bus.start = 1'b1;
        bus.read_rdy = 1'b1;
        bus.read_data_vld = 1'b0;
        bus.out_rdy = 1'b1;
        step();
        bus.start = 1'b0;
        chk("lim_err_clear", 32'(bus.err), 32'd0);
        n_en = 0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.read_en) n_en++;
            if (bus.done) dn++;
            step();
        end
        chk("lim_read_en_count", 32'(n_en), 32'd2);
        chk("lim_read_en_held", 32'(bus.read_en), 32'd0);
        bus.read_data = {4'h0, 12'd0, act_val(12'd0)};
        bus.read_data_vld = 1'b1;
        #1;
        chk("lim_recv_rdy", 32'(bus.read_data_rdy), 32'd1);
        chk("lim_read_en_still0", 32'(bus.read_en), 32'd0);
        step();
        bus.read_data_vld = 1'b0;
        #1;
        chk("lim_read_en_resume", 32'(bus.read_en), 32'd1);
        chk("lim_resume_addr", 32'(bus.read_addr), 32'h0800);

        // reset in the middle of the readout
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_read_en", 32'(bus.read_en), 32'd0);
        chk("mid_rst_read_addr", 32'(bus.read_addr), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        step();
        rst = 1'b0;
        bus.read_data = {4'h0, 12'd64, act_val(12'd64)};
        bus.read_data_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) dn++;
            step();
        end
        chk("late_data_rdy", 32'(bus.read_data_rdy), 32'd0);
        chk("late_out_vld", 32'(bus.out_vld), 32'd0);
        chk("late_busy", 32'(bus.busy), 32'd0);
        chk("late_err", 32'(bus.err), 32'd0);
        chk("mid_rst_no_done", 32'(dn), 32'd0);
        bus.read_data_vld = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
